// File: rtl/stopwatch_pkg.sv
// Shared types and limits for the stopwatch time counter and its key conditioner.
package stopwatch_pkg;

  localparam int MINS_W = 7;
  localparam int SECS_W = 6;
  localparam int DECS_W = 7;

  localparam logic [MINS_W-1:0] MAX_MINS = 7'd99;
  localparam logic [SECS_W-1:0] MAX_SECS = 6'd59;
  localparam logic [DECS_W-1:0] MAX_DECS = 7'd99;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } state_e;

endpackage

// File: rtl/stopwatch_key_cond.sv
// Pushbutton conditioner: 2-FF synchronizer, level debounce and a one-cycle pulse
// on each accepted press (high->low). Releases produce no event.
module stopwatch_key_cond #(
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_n_i,
  output logic press_o
);

  localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic [1:0]       sync_q;
  logic             last_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q;

  // Any change of the synchronized level restarts the stability window.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync_q[1] != last_q) begin
      cnt_d = '0;
    end else if (sync_q[1] != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync_q[1];
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Levels reset to the released (high) state so a key held through reset is seen as a fresh press.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q   <= 2'b11;
      last_q   <= 1'b1;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], key_n_i};
      last_q   <= sync_q[1];
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= stable_q & ~stable_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/stopwatch_time_counter.sv
// Stopwatch core: 100 Hz prescaler, min:sec:hundredths counter and control FSM.
// Define STOPWATCH_LAP_HOLD_EN to build the lap snapshot (LAP state) feature.
module stopwatch_time_counter
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int TICK_HZ      = 100,
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_start_n,
  input  logic              key_clear_n,
  output logic [MINS_W-1:0] stopwatch_unit_mins,
  output logic [SECS_W-1:0] stopwatch_unit_secs,
  output logic [DECS_W-1:0] stopwatch_unit_decs,
  output logic              running,
  output logic              overflow
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

  logic start_evt, clear_raw, clear_evt;

  stopwatch_key_cond #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_start (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .key_n_i (key_start_n),
    .press_o (start_evt)
  );

  stopwatch_key_cond #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_clear (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .key_n_i (key_clear_n),
    .press_o (clear_raw)
  );

  assign clear_evt = clear_raw & ~start_evt;

  state_e            state_q, state_d;
  logic [PRE_W-1:0]  presc_q, presc_d;
  logic [MINS_W-1:0] mins_q, mins_d;
  logic [SECS_W-1:0] secs_q, secs_d;
  logic [DECS_W-1:0] decs_q, decs_d;
  logic              overflow_q, overflow_d;
  logic              running_q, running_d;
  logic              counting, tick;
`ifdef STOPWATCH_LAP_HOLD_EN
  logic [MINS_W-1:0] lap_mins_q, lap_mins_d;
  logic [SECS_W-1:0] lap_secs_q, lap_secs_d;
  logic [DECS_W-1:0] lap_decs_q, lap_decs_d;
`endif

  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    mins_d     = mins_q;
    secs_d     = secs_q;
    decs_d     = decs_q;
    overflow_d = overflow_q;
`ifdef STOPWATCH_LAP_HOLD_EN
    lap_mins_d = lap_mins_q;
    lap_secs_d = lap_secs_q;
    lap_decs_d = lap_decs_q;
`endif
    counting = (state_q == RUN) || (state_q == LAP);
    tick     = counting && (presc_q == PRE_LAST);

    if (counting) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start_evt) state_d = RUN;
      end
      RUN: begin
        if (start_evt) begin
          state_d = PAUSE;
`ifdef STOPWATCH_LAP_HOLD_EN
        end else if (clear_evt) begin
          state_d    = LAP;
          lap_mins_d = mins_q;
          lap_secs_d = secs_q;
          lap_decs_d = decs_q;
`endif
        end
      end
      PAUSE: begin
        if (start_evt) begin
          if (!overflow_q) state_d = RUN;
        end else if (clear_evt) begin
          state_d    = IDLE;
          presc_d    = '0;
          mins_d     = '0;
          secs_d     = '0;
          decs_d     = '0;
          overflow_d = 1'b0;
        end
      end
`ifdef STOPWATCH_LAP_HOLD_EN
      LAP: begin
        if (start_evt)      state_d = PAUSE;
        else if (clear_evt) state_d = RUN;
      end
`endif
      default: state_d = IDLE;
    endcase

    // Saturation overrides any key-driven transition taken in the same cycle.
    if (tick) begin
      if (mins_q == MAX_MINS && secs_q == MAX_SECS && decs_q == MAX_DECS) begin
        overflow_d = 1'b1;
        state_d    = PAUSE;
      end else if (decs_q != MAX_DECS) begin
        decs_d = decs_q + 1'b1;
      end else begin
        decs_d = '0;
        if (secs_q != MAX_SECS) begin
          secs_d = secs_q + 1'b1;
        end else begin
          secs_d = '0;
          mins_d = mins_q + 1'b1;
        end
      end
    end

    running_d = (state_d == RUN) || (state_d == LAP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      presc_q    <= '0;
      mins_q     <= '0;
      secs_q     <= '0;
      decs_q     <= '0;
      overflow_q <= 1'b0;
      running_q  <= 1'b0;
`ifdef STOPWATCH_LAP_HOLD_EN
      lap_mins_q <= '0;
      lap_secs_q <= '0;
      lap_decs_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      mins_q     <= mins_d;
      secs_q     <= secs_d;
      decs_q     <= decs_d;
      overflow_q <= overflow_d;
      running_q  <= running_d;
`ifdef STOPWATCH_LAP_HOLD_EN
      lap_mins_q <= lap_mins_d;
      lap_secs_q <= lap_secs_d;
      lap_decs_q <= lap_decs_d;
`endif
    end
  end

  always_comb begin
`ifdef STOPWATCH_LAP_HOLD_EN
    if (state_q == LAP) begin
      stopwatch_unit_mins = lap_mins_q;
      stopwatch_unit_secs = lap_secs_q;
      stopwatch_unit_decs = lap_decs_q;
    end else begin
      stopwatch_unit_mins = mins_q;
      stopwatch_unit_secs = secs_q;
      stopwatch_unit_decs = decs_q;
    end
`else
    stopwatch_unit_mins = mins_q;
    stopwatch_unit_secs = secs_q;
    stopwatch_unit_decs = decs_q;
`endif
  end

  assign running  = running_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_stopwatch_time_counter.sv
// Directed bench for stopwatch_time_counter (DIV=10, DEBOUNCE_CYC=4); honours STOPWATCH_LAP_HOLD_EN.
module tb_stopwatch_time_counter;

  logic       clk;
  logic       rst_n;
  logic       key_start_n;
  logic       key_clear_n;
  logic [6:0] mins;
  logic [5:0] secs;
  logic [6:0] decs;
  logic       running;
  logic       overflow;

  int checks;
  int errors;
  // Clocks spent counting since the last clear; live value is elapsed/10 hundredths.
  int elapsed;
  bit counting;

  stopwatch_time_counter #(
    .CLK_HZ       (1000),
    .TICK_HZ      (100),
    .DEBOUNCE_CYC (4)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .key_start_n         (key_start_n),
    .key_clear_n         (key_clear_n),
    .stopwatch_unit_mins (mins),
    .stopwatch_unit_secs (secs),
    .stopwatch_unit_decs (decs),
    .running             (running),
    .overflow            (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [19:0] model_units();
    logic [6:0] m;
    logic [5:0] s;
    logic [6:0] d;
    m = 7'(elapsed / 60000);
    s = 6'((elapsed / 1000) % 60);
    d = 7'((elapsed / 10) % 100);
    return {m, s, d};
  endfunction

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (counting) elapsed++;
      @(negedge clk);
    end
  endtask

  task automatic press_until(input bit use_start, input bit use_clear, input bit want_run);
    bit ok;
    ok = 1'b0;
    if (use_start) key_start_n = 1'b0;
    if (use_clear) key_clear_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      if (counting) elapsed++;
      @(negedge clk);
      if (running === want_run) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL press_timeout: running=%0b want %0b", running, want_run);
    end
    counting    = want_run;
    key_start_n = 1'b1;
    key_clear_n = 1'b1;
    step(12);
  endtask

  task automatic press_fixed(input bit use_start, input bit use_clear);
    if (use_start) key_start_n = 1'b0;
    if (use_clear) key_clear_n = 1'b0;
    step(10);
    key_start_n = 1'b1;
    key_clear_n = 1'b1;
    step(12);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    key_start_n = 1'b1;
    key_clear_n = 1'b1;
    counting = 1'b0;
    elapsed = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({mins, secs, decs, running, overflow} !== 22'd0) begin
      errors++;
      $display("[TB] FAIL reset_hold: got %0d:%0d.%0d run=%0b ovf=%0b want all 0", mins, secs, decs, running, overflow);
    end
    rst_n = 1'b1;
    step(5);
    checks++;
    if ({mins, secs, decs, running, overflow} !== 22'd0) begin
      errors++;
      $display("[TB] FAIL reset_release: got %0d:%0d.%0d run=%0b ovf=%0b want all 0", mins, secs, decs, running, overflow);
    end
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 10; i++) begin
      key_start_n = (i % 2 == 1);
      step(2);
    end
    key_start_n = 1'b1;
    step(12);
    checks++;
    if (running !== 1'b0 || {mins, secs, decs} !== 20'd0) begin
      errors++;
      $display("[TB] FAIL bounce_ignored: run=%0b units %0d:%0d.%0d want run=0 0:0.0", running, mins, secs, decs);
    end
  endtask

  task automatic test_run_count();
    bit ok;
    ok = 1'b0;
    key_start_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (running === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL start_to_run: running=%0b want 1", running);
    end
    counting = 1'b1;
    elapsed = 0;
    key_start_n = 1'b1;
    step(150);
    checks++;
    if ({mins, secs, decs} !== {7'd0, 6'd0, 7'd15}) begin
      errors++;
      $display("[TB] FAIL run_150clk: got %0d:%0d.%0d want 0:0.15", mins, secs, decs);
    end
  endtask

  task automatic test_pause_clear();
    logic [19:0] exp;
    press_until(1'b1, 1'b0, 1'b0);
    exp = model_units();
    checks++;
    if ({mins, secs, decs} !== exp) begin
      errors++;
      $display("[TB] FAIL pause_value: got %0d:%0d.%0d want %0d:%0d.%0d", mins, secs, decs, exp[19:13], exp[12:7], exp[6:0]);
    end
    step(100);
    checks++;
    if ({mins, secs, decs} !== exp || running !== 1'b0) begin
      errors++;
      $display("[TB] FAIL pause_frozen: got %0d:%0d.%0d run=%0b want %0d:%0d.%0d run=0", mins, secs, decs, running, exp[19:13], exp[12:7], exp[6:0]);
    end
    press_fixed(1'b0, 1'b1);
    elapsed = 0;
    checks++;
    if ({mins, secs, decs, running, overflow} !== 22'd0) begin
      errors++;
      $display("[TB] FAIL pause_clear_idle: got %0d:%0d.%0d run=%0b ovf=%0b want all 0", mins, secs, decs, running, overflow);
    end
  endtask

  task automatic test_lap();
    logic [19:0] exp;
    press_until(1'b1, 1'b0, 1'b1);
    step(200 - elapsed);
`ifdef STOPWATCH_LAP_HOLD_EN
    exp = model_units();
    press_fixed(1'b0, 1'b1);
    checks++;
    if ({mins, secs, decs} !== exp || running !== 1'b1) begin
      errors++;
      $display("[TB] FAIL lap_snapshot: got %0d:%0d.%0d run=%0b want %0d:%0d.%0d run=1", mins, secs, decs, running, exp[19:13], exp[12:7], exp[6:0]);
    end
    step(100);
    checks++;
    if ({mins, secs, decs} !== exp) begin
      errors++;
      $display("[TB] FAIL lap_hold: got %0d:%0d.%0d want %0d:%0d.%0d", mins, secs, decs, exp[19:13], exp[12:7], exp[6:0]);
    end
    press_fixed(1'b0, 1'b1);
    exp = model_units();
    checks++;
    if ({mins, secs, decs} !== exp || running !== 1'b1) begin
      errors++;
      $display("[TB] FAIL lap_return_live: got %0d:%0d.%0d run=%0b want %0d:%0d.%0d run=1", mins, secs, decs, running, exp[19:13], exp[12:7], exp[6:0]);
    end
`else
    press_fixed(1'b0, 1'b1);
    exp = model_units();
    checks++;
    if ({mins, secs, decs} !== exp || running !== 1'b1) begin
      errors++;
      $display("[TB] FAIL clear_in_run_ignored: got %0d:%0d.%0d run=%0b want %0d:%0d.%0d run=1", mins, secs, decs, running, exp[19:13], exp[12:7], exp[6:0]);
    end
`endif
  endtask

  task automatic test_both_keys();
    logic [19:0] exp;
    press_until(1'b1, 1'b1, 1'b0);
    step(30);
    exp = model_units();
    checks++;
    if ({mins, secs, decs} !== exp || overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL both_keys_pause: got %0d:%0d.%0d ovf=%0b want %0d:%0d.%0d ovf=0", mins, secs, decs, overflow, exp[19:13], exp[12:7], exp[6:0]);
    end
  endtask

  task automatic test_overflow();
    logic [19:0] exp;
    bit ok;
    // Preload through the paused counters; the prescaler phase is kept in elapsed%10.
    force dut.mins_q = 7'd0;
    force dut.secs_q = 6'd59;
    force dut.decs_q = 7'd99;
    step(1);
    release dut.mins_q;
    release dut.secs_q;
    release dut.decs_q;
    step(1);
    elapsed = 5999 * 10 + (elapsed % 10);
    press_until(1'b1, 1'b0, 1'b1);
    exp = model_units();
    checks++;
    if ({mins, secs, decs} !== exp || mins !== 7'd1) begin
      errors++;
      $display("[TB] FAIL carry_to_minute: got %0d:%0d.%0d want %0d:%0d.%0d", mins, secs, decs, exp[19:13], exp[12:7], exp[6:0]);
    end
    press_until(1'b1, 1'b0, 1'b0);
    force dut.mins_q = 7'd99;
    force dut.secs_q = 6'd59;
    force dut.decs_q = 7'd99;
    step(1);
    release dut.mins_q;
    release dut.secs_q;
    release dut.decs_q;
    step(1);
    ok = 1'b0;
    key_start_n = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (overflow === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    key_start_n = 1'b1;
    counting = 1'b0;
    step(12);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL overflow_timeout: overflow=%0b want 1", overflow);
    end
    checks++;
    if ({mins, secs, decs} !== {7'd99, 6'd59, 7'd99} || running !== 1'b0 || overflow !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overflow_saturate: got %0d:%0d.%0d run=%0b ovf=%0b want 99:59.99 run=0 ovf=1", mins, secs, decs, running, overflow);
    end
    press_fixed(1'b1, 1'b0);
    step(30);
    checks++;
    if ({mins, secs, decs} !== {7'd99, 6'd59, 7'd99} || running !== 1'b0 || overflow !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overflow_start_ignored: got %0d:%0d.%0d run=%0b ovf=%0b want 99:59.99 run=0 ovf=1", mins, secs, decs, running, overflow);
    end
    press_fixed(1'b0, 1'b1);
    elapsed = 0;
    checks++;
    if ({mins, secs, decs, running, overflow} !== 22'd0) begin
      errors++;
      $display("[TB] FAIL overflow_clear: got %0d:%0d.%0d run=%0b ovf=%0b want all 0", mins, secs, decs, running, overflow);
    end
  endtask

  task automatic test_async_reset();
    press_until(1'b1, 1'b0, 1'b1);
    step(35);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({mins, secs, decs, running, overflow} !== 22'd0) begin
      errors++;
      $display("[TB] FAIL async_reset: got %0d:%0d.%0d run=%0b ovf=%0b want all 0", mins, secs, decs, running, overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    counting = 1'b0;
    elapsed = 0;
    step(20);
    checks++;
    if ({mins, secs, decs, running, overflow} !== 22'd0) begin
      errors++;
      $display("[TB] FAIL after_async_reset: got %0d:%0d.%0d run=%0b ovf=%0b want all 0", mins, secs, decs, running, overflow);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_bounce();
    test_run_count();
    test_pause_clear();
    test_lap();
    test_both_keys();
    test_overflow();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
